// File: rtl/mult_control_if.sv
// Handshake between the shift-add multiplier controller and its datapath.
// The master side issues requests and reports datapath status; the slave is the controller.
interface mult_control_if;
  logic start;
  logic mult_lsb;
  logic stop;
  logic start_mult_sign;
  logic product_sign;
  logic multipliar_sign;
  logic count_sign;
  logic busy;
  logic done;
  logic error;

  modport master (
    output start, mult_lsb, stop,
    input  start_mult_sign, product_sign, multipliar_sign, count_sign, busy, done, error
  );

  modport slave (
    input  start, mult_lsb, stop,
    output start_mult_sign, product_sign, multipliar_sign, count_sign, busy, done, error
  );
endinterface

// File: rtl/mult_control.sv
// Moore sequencer for a shift-add multiplier: load, test LSB, optional add, shift,
// repeated until the datapath raises stop, or a timeout after WIDTH iterations.
module mult_control #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic         clk,
  input  logic         reset,
  mult_control_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, TEST, ADD, SHIFT, DONE, ERR} state_t;

  localparam logic [CW-1:0] ITER_MAX = CW'(WIDTH);

  state_t        state_q, state_d;
  logic [CW-1:0] iter_q, iter_d;
  logic          start_mult_sign_q, start_mult_sign_d;
  logic          product_sign_q, product_sign_d;
  logic          multipliar_sign_q, multipliar_sign_d;
  logic          count_sign_q, count_sign_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = LOAD;
      LOAD: begin
        state_d = TEST;
        iter_d  = '0;
      end
      // stop outranks the timeout so a finish on the last iteration is not an error
      TEST: begin
        if (bus.stop)                state_d = DONE;
        else if (iter_q == ITER_MAX) state_d = ERR;
        else if (bus.mult_lsb)       state_d = ADD;
        else                         state_d = SHIFT;
      end
      ADD:     state_d = SHIFT;
      SHIFT: begin
        state_d = TEST;
        if (iter_q != ITER_MAX) iter_d = iter_q + CW'(1);
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // outputs are registered copies of the next-state decode
    start_mult_sign_d = (state_d == LOAD);
    product_sign_d    = (state_d == ADD);
    multipliar_sign_d = (state_d == SHIFT);
    count_sign_d      = (state_d == SHIFT);
    busy_d            = (state_d != IDLE);
    done_d            = (state_d == DONE) || (state_d == ERR);
    error_d           = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q           <= IDLE;
      iter_q            <= '0;
      start_mult_sign_q <= 1'b0;
      product_sign_q    <= 1'b0;
      multipliar_sign_q <= 1'b0;
      count_sign_q      <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      iter_q            <= iter_d;
      start_mult_sign_q <= start_mult_sign_d;
      product_sign_q    <= product_sign_d;
      multipliar_sign_q <= multipliar_sign_d;
      count_sign_q      <= count_sign_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
    end
  end

  assign bus.start_mult_sign = start_mult_sign_q;
  assign bus.product_sign    = product_sign_q;
  assign bus.multipliar_sign = multipliar_sign_q;
  assign bus.count_sign      = count_sign_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.error           = error_q;

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control: a small datapath stand-in drives mult_lsb/stop, and an
// operation-level schedule model predicts every output cycle by cycle.
module tb_mult_control;
  localparam int W = 32;

  // output vector order: {start_mult_sign, product_sign, multipliar_sign, count_sign, busy, done, error}
  localparam logic [6:0] V_IDLE  = 7'b0000000;
  localparam logic [6:0] V_LOAD  = 7'b1000100;
  localparam logic [6:0] V_TEST  = 7'b0000100;
  localparam logic [6:0] V_ADD   = 7'b0100100;
  localparam logic [6:0] V_SHIFT = 7'b0011100;
  localparam logic [6:0] V_DONE  = 7'b0000110;
  localparam logic [6:0] V_ERR   = 7'b0000111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_control_if bus();
  mult_control #(.WIDTH(W), .CW(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // operation parameters shared by stimulus, datapath stand-in and model
  logic [W-1:0] operand = '0;
  int           stop_at = W;
  bit           stop_en = 1'b1;
  bit           spur    = 1'b0;

  // running totals kept by the compare process
  int load_tot = 0, add_tot = 0, done_tot = 0, err_tot = 0;
  int cyc = 0, last_done_cyc = -1;

  logic [6:0]   expq[$];
  logic [W-1:0] mreg = '0;
  int           scnt = 0;
  logic         prev_done = 1'b0;

  function automatic logic [6:0] outs();
    return {bus.start_mult_sign, bus.product_sign, bus.multipliar_sign, bus.count_sign,
            bus.busy, bus.done, bus.error};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // one operation: LOAD, then per iteration TEST [ADD if bit set] SHIFT, then TEST and the ending
  task automatic build_schedule();
    expq.push_back(V_LOAD);
    for (int i = 0; i < stop_at; i++) begin
      expq.push_back(V_TEST);
      if (operand[i]) expq.push_back(V_ADD);
      expq.push_back(V_SHIFT);
    end
    expq.push_back(V_TEST);
    expq.push_back(stop_en ? V_DONE : V_ERR);
  endtask

  always @(negedge clk) begin : cmp
    logic [6:0] act;
    logic [6:0] expv;
    act = outs();
    cyc++;
    if (reset) begin
      expq.delete();
      expv = V_IDLE;
    end else if (expq.size() == 0) expv = V_IDLE;
    else expv = expq.pop_front();

    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL outputs: actual=%b required=%b (cyc=%0d t=%0t)", act, expv, cyc, $time);
    end
    vectors++;
    if (($countones(act[6:4]) > 1) || (act[3] !== act[4]) || (act[0] && !act[1]) ||
        (prev_done && act[1])) begin
      miscompares++;
      $display("FAIL invariants: actual=%b required=exclusive strobes, single done (t=%0t)", act, $time);
    end
    prev_done = act[1];

    if (act[6]) load_tot++;
    if (act[5]) add_tot++;
    if (act[1]) begin done_tot++; last_done_cyc = cyc; end
    if (act[0]) err_tot++;

    if (!reset && expv == V_IDLE && expq.size() == 0 && bus.start === 1'b1) begin
      build_schedule();
      cyc = 0;
    end

    // datapath stand-in reacts to the strobes it just saw
    if (act[6]) begin mreg = operand; scnt = 0; end
    else if (act[4]) begin mreg = mreg >> 1; scnt++; end
    bus.mult_lsb = mreg[0];
    bus.stop = (stop_en && scnt >= stop_at) || (spur && (act[6] | act[5] | act[4]));
  end

  task automatic start_op(input logic [W-1:0] op, input int sat, input bit sen, input bit sp);
    operand = op; stop_at = sat; stop_en = sen; spur = sp;
    @(posedge clk); #2 bus.start = 1'b1;
    @(posedge clk); #2 bus.start = 1'b0;
  endtask

  task automatic run(input string name, input logic [W-1:0] op, input int sat, input bit sen,
                     input bit sp, input int exp_cyc, input int exp_add, input int exp_err,
                     input int repulse);
    int lb, ab, db, eb, n;
    bit seen;
    lb = load_tot; ab = add_tot; db = done_tot; eb = err_tot;
    start_op(op, sat, sen, sp);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_tot > db) seen = 1'b1;
      else if (bus.multipliar_sign && n < repulse) begin
        n++;
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
      end
    end
    chk({name, "_timeout"}, int'(seen), 1);
    chk({name, "_done_cycle"}, last_done_cyc, exp_cyc);
    chk({name, "_loads"}, load_tot - lb, 1);
    chk({name, "_adds"}, add_tot - ab, exp_add);
    chk({name, "_errors"}, err_tot - eb, exp_err);
    repeat (3) @(posedge clk);
    #2 chk({name, "_done_count"}, done_tot - db, 1);
  endtask

  initial begin
    int db, lb;
    bit seen;
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("reset_outputs", int'(outs()), 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("idle_after_release", int'(outs()), 0);

    run("mult_one",  32'h0000_0001, W, 1'b1, 1'b0, 68, 1,  0, 0);
    run("mult_zero", 32'h0000_0000, W, 1'b1, 1'b0, 67, 0,  0, 0);
    run("mult_ones", 32'hFFFF_FFFF, W, 1'b1, 1'b0, 99, 32, 0, 0);
    run("timeout",   32'h0000_0000, W, 1'b0, 1'b1, 67, 0,  1, 0);
    run("early_stop", 32'h0000_00A5, 5, 1'b1, 1'b1, 15, 2, 0, 0);
    run("restart_ignored", 32'h0000_0003, W, 1'b1, 1'b0, 69, 2, 0, 3);

    // start held high across DONE starts a second operation after one IDLE cycle
    db = done_tot; lb = load_tot;
    operand = 32'h0; stop_at = 2; stop_en = 1'b1; spur = 1'b0;
    @(posedge clk); #2 bus.start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_tot - db >= 2) seen = 1'b1;
    end
    bus.start = 1'b0;
    chk("held_start_timeout", int'(seen), 1);
    chk("held_start_loads", load_tot - lb, 2);
    chk("held_start_done_cycle", last_done_cyc, 7);
    repeat (3) @(posedge clk);

    // reset during ADD aborts silently
    db = done_tot;
    start_op(32'h0000_0001, W, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk); #1;
      if (bus.product_sign) seen = 1'b1;
    end
    chk("reach_add", int'(seen), 1);
    reset = 1'b1;
    #1 chk("reset_in_add_outputs", int'(outs()), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("reset_in_add_no_done", done_tot - db, 0);
    chk("reset_in_add_idle", int'(outs()), 0);
    run("after_reset", 32'h0000_0001, W, 1'b1, 1'b0, 68, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
